// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared types and defaults for the MEM->WB skid pipeline register.
package mem_wb_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic                 wb_en;
    logic                 mem_r;
    logic [RF_DATA_W-1:0] alu_res;
    logic [RF_DATA_W-1:0] mem_res;
    logic [RF_ADDR_W-1:0] dest;
  } entry_t;

endpackage

// File: rtl/mem_wb_skid_reg_if.sv
// Handshake/payload bundle between MEM, the skid register and WB.
// MEM_WB_FWD_EN adds the forwarding taps on the head entry.
interface mem_wb_skid_reg_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              wb_en_in;
  logic              mem_r_in;
  logic [DATA_W-1:0] alu_res_in;
  logic [DATA_W-1:0] mem_res_in;
  logic [DEST_W-1:0] dest_in;
  logic              out_valid;
  logic              out_ready;
  logic              wb_en_out;
  logic              mem_r_out;
  logic [DATA_W-1:0] alu_res_out;
  logic [DATA_W-1:0] mem_res_out;
  logic [DEST_W-1:0] dest_out;
  logic [1:0]        occupancy;
`ifdef MEM_WB_FWD_EN
  logic              fwd_valid;
  logic [DEST_W-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_data;
`endif

  modport slave (
    input  flush, in_valid, wb_en_in, mem_r_in, alu_res_in, mem_res_in, dest_in, out_ready,
    output in_ready, out_valid, wb_en_out, mem_r_out, alu_res_out, mem_res_out, dest_out,
           occupancy
`ifdef MEM_WB_FWD_EN
    , output fwd_valid, fwd_dest, fwd_data
`endif
  );

  modport master (
    output flush, in_valid, wb_en_in, mem_r_in, alu_res_in, mem_res_in, dest_in, out_ready,
    input  in_ready, out_valid, wb_en_out, mem_r_out, alu_res_out, mem_res_out, dest_out,
           occupancy
`ifdef MEM_WB_FWD_EN
    , input fwd_valid, fwd_dest, fwd_data
`endif
  );
endinterface

// File: rtl/mem_wb_skid_reg_entry.sv
// Load-enabled payload register with synchronous clear; used for head and skid slots.
module mem_wb_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)
      data_q <= '0;
    else if (ld_i)
      data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Define MEM_WB_FWD_EN to expose head-entry forwarding outputs.
module mem_wb_skid_reg
  import mem_wb_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEST_W = RF_ADDR_W
) (
  input logic              clk,
  input logic              rst,
  mem_wb_skid_reg_if.slave bus
);
  localparam int EW     = 2 + 2 * DATA_W + DEST_W;
  localparam int WB_B   = EW - 1;
  localparam int MR_B   = EW - 2;
  localparam int ALU_LO = DEST_W + DATA_W;
  localparam int MEM_LO = DEST_W;

  state_e        state_q, state_d;
  logic          in_fire, out_fire;
  logic          head_ld, skid_ld, head_from_skid;
  logic [EW-1:0] in_vec, head_d, head_q, skid_q;

  assign in_vec = {bus.wb_en_in, bus.mem_r_in, bus.alu_res_in, bus.mem_res_in, bus.dest_in};

  assign bus.in_ready  = (state_q != TWO);
  assign bus.out_valid = (state_q != EMPTY);
  assign in_fire       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign out_fire      = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    head_ld        = 1'b0;
    skid_ld        = 1'b0;
    head_from_skid = 1'b0;
    if (bus.flush) begin
      // Payload is left stale; wb_en_out is gated by out_valid so nothing commits.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            head_ld = 1'b1;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            head_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld = 1'b1;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  assign head_d = head_from_skid ? skid_q : in_vec;

  // ---- storage slots ----
  mem_wb_entry_reg #(.W(EW)) u_head (
    .clk  (clk),
    .rst  (rst),
    .ld_i (head_ld),
    .d_i  (head_d),
    .q_o  (head_q)
  );

  mem_wb_entry_reg #(.W(EW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .ld_i (skid_ld),
    .d_i  (in_vec),
    .q_o  (skid_q)
  );

  // ---- head outputs ----
  assign bus.wb_en_out   = head_q[WB_B] & bus.out_valid;
  assign bus.mem_r_out   = head_q[MR_B];
  assign bus.alu_res_out = head_q[ALU_LO +: DATA_W];
  assign bus.mem_res_out = head_q[MEM_LO +: DATA_W];
  assign bus.dest_out    = head_q[DEST_W-1:0];
  assign bus.occupancy   = state_q;

`ifdef MEM_WB_FWD_EN
  assign bus.fwd_valid = bus.out_valid & head_q[WB_B];
  assign bus.fwd_dest  = head_q[DEST_W-1:0];
  assign bus.fwd_data  = head_q[MR_B] ? head_q[MEM_LO +: DATA_W] : head_q[ALU_LO +: DATA_W];
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Bench for mem_wb_skid_reg: directed vector table, forwarding checks, randomized run vs a queue model.
module tb_mem_wb_skid_reg;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam logic [DW-1:0] MEM_XOR = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_skid_reg_if #(.DATA_W(DW), .DEST_W(AW)) bus ();

  mem_wb_skid_reg #(.DATA_W(DW), .DEST_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rst, flush, vld, ordy, wb, mr;
    logic [DW-1:0] alu;
    logic [AW-1:0] dest;
    logic [1:0]    e_occ;
    logic          e_ov, e_ir, e_wb, chk_pay;
    logic [DW-1:0] e_alu;
    logic [AW-1:0] e_dest;
  } vec_t;

  function automatic vec_t mk(logic r, logic f, logic v, logic o, logic wb,
                              logic [DW-1:0] alu, logic [AW-1:0] d,
                              logic [1:0] eo, logic eov, logic eir, logic ewb,
                              logic cp, logic [DW-1:0] ea, logic [AW-1:0] ed);
    vec_t x;
    x.rst = r; x.flush = f; x.vld = v; x.ordy = o; x.wb = wb; x.mr = 1'b0;
    x.alu = alu; x.dest = d;
    x.e_occ = eo; x.e_ov = eov; x.e_ir = eir; x.e_wb = ewb;
    x.chk_pay = cp; x.e_alu = ea; x.e_dest = ed;
    return x;
  endfunction

  task automatic drive(logic r, logic f, logic v, logic o, logic wb, logic mr,
                       logic [DW-1:0] alu, logic [DW-1:0] mem, logic [AW-1:0] d);
    rst = r;
    bus.flush = f; bus.in_valid = v; bus.out_ready = o;
    bus.wb_en_in = wb; bus.mem_r_in = mr;
    bus.alu_res_in = alu; bus.mem_res_in = mem; bus.dest_in = d;
  endtask

  typedef struct {
    logic          wb, mr;
    logic [DW-1:0] alu, mem;
    logic [AW-1:0] dest;
  } ent_t;

  vec_t vt[$];
  ent_t q[$];

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);

    //             rst flu vld ord wb  alu       dest  occ ov ir wb cp e_alu     e_dest
    vt.push_back(mk(1, 0, 1, 0, 1, 32'h55,  4'd0,  2'd0, 0, 1, 0, 1, 32'h0,  4'd0));
    vt.push_back(mk(1, 0, 1, 0, 1, 32'h55,  4'd0,  2'd0, 0, 1, 0, 1, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 0, 1, 1, 32'h0,   4'd0,  2'd0, 0, 1, 0, 1, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 1, 1, 1, 32'h10,  4'd1,  2'd1, 1, 1, 1, 1, 32'h10, 4'd1));
    vt.push_back(mk(0, 0, 1, 1, 1, 32'h11,  4'd2,  2'd1, 1, 1, 1, 1, 32'h11, 4'd2));
    vt.push_back(mk(0, 0, 1, 1, 1, 32'h12,  4'd3,  2'd1, 1, 1, 1, 1, 32'h12, 4'd3));
    vt.push_back(mk(0, 0, 0, 1, 1, 32'h0,   4'd0,  2'd0, 0, 1, 0, 0, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hA0,  4'd4,  2'd1, 1, 1, 1, 1, 32'hA0, 4'd4));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hA1,  4'd5,  2'd2, 1, 0, 1, 1, 32'hA0, 4'd4));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hA2,  4'd6,  2'd2, 1, 0, 1, 1, 32'hA0, 4'd4));
    vt.push_back(mk(0, 0, 1, 1, 1, 32'hA2,  4'd6,  2'd1, 1, 1, 1, 1, 32'hA1, 4'd5));
    vt.push_back(mk(0, 0, 1, 1, 1, 32'hA2,  4'd6,  2'd1, 1, 1, 1, 1, 32'hA2, 4'd6));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h0,   4'd0,  2'd1, 1, 1, 1, 1, 32'hA2, 4'd6));
    vt.push_back(mk(0, 0, 0, 1, 1, 32'h0,   4'd0,  2'd0, 0, 1, 0, 0, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hC0,  4'd7,  2'd1, 1, 1, 1, 1, 32'hC0, 4'd7));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hC1,  4'd8,  2'd2, 1, 0, 1, 1, 32'hC0, 4'd7));
    vt.push_back(mk(0, 1, 1, 0, 1, 32'hB0,  4'd9,  2'd0, 0, 1, 0, 0, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 0, 1, 1, 32'h0,   4'd0,  2'd0, 0, 1, 0, 0, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hD0,  4'd10, 2'd1, 1, 1, 1, 1, 32'hD0, 4'd10));
    vt.push_back(mk(0, 1, 1, 1, 1, 32'hE0,  4'd12, 2'd0, 0, 1, 0, 0, 32'h0,  4'd0));
    vt.push_back(mk(0, 0, 1, 0, 0, 32'hF0,  4'd11, 2'd1, 1, 1, 0, 1, 32'hF0, 4'd11));
    vt.push_back(mk(0, 0, 1, 0, 1, 32'hF1,  4'd13, 2'd2, 1, 0, 0, 1, 32'hF0, 4'd11));
    vt.push_back(mk(1, 0, 1, 1, 1, 32'hF2,  4'd14, 2'd0, 0, 1, 0, 1, 32'h0,  4'd0));

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].flush, vt[i].vld, vt[i].ordy, vt[i].wb, vt[i].mr,
            vt[i].alu, vt[i].alu ^ MEM_XOR, vt[i].dest);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d occupancy", i), 64'(bus.occupancy), 64'(vt[i].e_occ));
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vt[i].e_ov));
      chk($sformatf("v%0d in_ready", i),  64'(bus.in_ready),  64'(vt[i].e_ir));
      chk($sformatf("v%0d wb_en_out", i), 64'(bus.wb_en_out), 64'(vt[i].e_wb));
      if (vt[i].chk_pay) begin
        chk($sformatf("v%0d alu_res_out", i), 64'(bus.alu_res_out), 64'(vt[i].e_alu));
        chk($sformatf("v%0d dest_out", i),    64'(bus.dest_out),    64'(vt[i].e_dest));
        chk($sformatf("v%0d mem_r_out", i),   64'(bus.mem_r_out),   64'(1'b0));
        if (vt[i].e_ov)
          chk($sformatf("v%0d mem_res_out", i), 64'(bus.mem_res_out), 64'(vt[i].e_alu ^ MEM_XOR));
        else
          chk($sformatf("v%0d mem_res_out", i), 64'(bus.mem_res_out), 64'(0));
      end
    end

`ifdef MEM_WB_FWD_EN
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'hDEAD, 4'd5);
    @(posedge clk); #1;
    chk("fwd load valid", 64'(bus.fwd_valid), 64'(1'b1));
    chk("fwd load dest",  64'(bus.fwd_dest),  64'(4'd5));
    chk("fwd load data",  64'(bus.fwd_data),  64'(32'hDEAD));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hDEAD, 4'd5);
    @(posedge clk); #1;
    chk("fwd alu valid", 64'(bus.fwd_valid), 64'(1'b1));
    chk("fwd alu data",  64'(bus.fwd_data),  64'(32'h100));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'hDEAD, 4'd5);
    @(posedge clk); #1;
    chk("fwd nowb valid", 64'(bus.fwd_valid), 64'(1'b0));
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
`endif

    // Randomized traffic against an ordered-queue model of at most two entries.
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      ent_t e;
      logic r, f, v, o;
      bit   take;
      @(negedge clk);
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 15) == 0);
      v = 1'($urandom_range(0, 1));
      o = ($urandom_range(0, 2) != 0);
      e.wb = 1'($urandom_range(0, 1));
      e.mr = 1'($urandom_range(0, 1));
      e.alu = $urandom();
      e.mem = $urandom();
      e.dest = 4'($urandom_range(0, 15));
      drive(r, f, v, o, e.wb, e.mr, e.alu, e.mem, e.dest);
      if (r || f) begin
        q.delete();
      end else begin
        take = v && (q.size() < 2);
        if (q.size() > 0 && o) void'(q.pop_front());
        if (take) q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("rnd occupancy", 64'(bus.occupancy), 64'(q.size()));
      chk("rnd out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("rnd in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd wb_en_out",   64'(bus.wb_en_out),   64'(q[0].wb));
        chk("rnd mem_r_out",   64'(bus.mem_r_out),   64'(q[0].mr));
        chk("rnd alu_res_out", 64'(bus.alu_res_out), 64'(q[0].alu));
        chk("rnd mem_res_out", 64'(bus.mem_res_out), 64'(q[0].mem));
        chk("rnd dest_out",    64'(bus.dest_out),    64'(q[0].dest));
      end else begin
        chk("rnd wb_en_out idle", 64'(bus.wb_en_out), 64'(1'b0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
Parametrised MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer. It carries write-back enable, the load flag, the ALU result, the memory result and the destination register. The block adds stall/backpressure and flush, which a plain latch-every-cycle stage register lacks. It sits between the MEM stage (upstream producer) and the WB stage/register file (downstream consumer).

Parameters:
DATA_W, 32, width of alu_res and mem_res (register file word)
DEST_W, 4, width of destination register address

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries this cycle
in_valid  in  1  upstream presents an entry
in_ready  out  1  block can accept an entry
wb_en_in  in  1  entry writes the register file
mem_r_in  in  1  entry is a load (WB selects mem_res)
alu_res_in  in  DATA_W  ALU result
mem_res_in  in  DATA_W  memory read data
dest_in  in  DEST_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  WB consumes head entry
wb_en_out  out  1  head wb_en gated by out_valid
mem_r_out  out  1  head load flag
alu_res_out  out  DATA_W  head ALU result
mem_res_out  out  DATA_W  head memory data
dest_out  out  DEST_W  head destination
occupancy  out  2  entries held, 0..2

Behaviour:
- Clock: single clk. Reset: synchronous, active-high rst. All state updates happen on the rising edge.
- Storage: head slot (drives the outputs) and skid slot. State is EMPTY, ONE or TWO; occupancy = 0/1/2.
- in_ready = (state != TWO). It is a combinational decode of registered state only and does not depend on out_ready.
- in_fire = in_valid & in_ready & !flush.
- out_fire = out_valid & out_ready.
- out_valid = (state != EMPTY).
- Transitions:
  - EMPTY: in_fire -> head<=in, go to ONE.
  - ONE, in_fire & !out_fire -> skid<=in, go to TWO.
  - ONE, in_fire & out_fire -> head<=in, stay in ONE.
  - ONE, !in_fire & out_fire -> go to EMPTY.
  - TWO, out_fire -> head<=skid, go to ONE. No input is accepted in TWO.
  - Otherwise hold.
- Ordering: strict FIFO. The skid entry never bypasses the head.
- Latency: an accepted entry appears on the outputs the cycle after acceptance if the block was EMPTY, or after one out_fire per older entry otherwise.
- Flush has priority over everything except rst. Next state is EMPTY. An entry presented in the flush cycle is dropped even though in_ready may read 1. Payload registers may hold stale data.
- wb_en_out = head.wb_en & out_valid, so no register-file write can occur from a stale or flushed slot. The other payload outputs are don't-care when out_valid=0.
- Reset: state EMPTY, occupancy 0, out_valid 0, wb_en_out 0, mem_r_out 0, alu_res_out 0, mem_res_out 0, dest_out 0. in_ready is 1 in the first cycle after reset.
- rst during TWO discards both entries with no partial update.
- out_ready held high gives full throughput: one entry per cycle, occupancy never exceeds 1.

Optional Feature:
MEM_WB_FWD_EN defined adds three outputs:
- fwd_valid: 1 = out_valid & head.wb_en.
- fwd_dest: DEST_W = head.dest.
- fwd_data: DATA_W = head.mem_r ? head.mem_res : head.alu_res.

These feed the forwarding unit, so the head result is available before WB commits. When the macro is undefined the ports are absent and the block is unchanged otherwise.

Decomposition:
- Shared package mem_wb_pkg holds:
  - DATA_W/DEST_W defaults, matching the register-file length/address constants.
  - State enum {EMPTY, ONE, TWO}.
  - Packed entry struct {wb_en, mem_r, alu_res, mem_res, dest}.
- One natural sub-module: mem_wb_entry_reg, a load-enabled payload register with synchronous reset, instantiated twice (head, skid).

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> occupancy=0, out_valid=0, wb_en_out=0, alu_res_out=0; in_ready=1 the cycle after rst drops.
- Streaming: out_ready=1; inject alu_res 0x10,0x11,0x12 with dest 1,2,3 on consecutive cycles -> each appears one cycle later, in order; occupancy stays 1.
- Backpressure: out_ready=0; inject 0xA0 then 0xA1 -> occupancy=2, in_ready=0, and a third input 0xA2 is not accepted. Raise out_ready -> 0xA0 then 0xA1 are output; 0xA2 is accepted once in_ready=1.
- Flush: occupancy=2, flush=1 with in_valid=1 carrying 0xB0 -> next cycle occupancy=0, out_valid=0, wb_en_out=0; 0xB0 never appears.
- Load select (MEM_WB_FWD_EN): entry mem_r=1, alu=0x100, mem=0xDEAD, dest=5, wb_en=1 -> fwd_valid=1, fwd_dest=5, fwd_data=0xDEAD. Same entry with mem_r=0 -> fwd_data=0x100. Same entry with wb_en=0 -> fwd_valid=0.
